// File: rtl/pb_serial_adder_if.sv
// Operand, button and result signals of the push-button serial adder.
// The master side drives switches and buttons; the slave side is the adder.
interface pb_serial_adder_if #(
  parameter int WIDTH = 7
);
  logic [WIDTH-1:0] sw;
  logic             cin;
  logic             PB1;
  logic             PB2;
  logic             PB3;
  logic             PB4;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic             cout;
  logic             a_valid;
  logic             b_valid;
  logic             busy;
  logic             done;

  modport master (
    output sw, cin, PB1, PB2, PB3, PB4,
    input  sum, carry, cout, a_valid, b_valid, busy, done
  );

  modport slave (
    input  sw, cin, PB1, PB2, PB3, PB4,
    output sum, carry, cout, a_valid, b_valid, busy, done
  );
endinterface

// File: rtl/pb_serial_adder.sv
// Bit-serial ripple adder driven by four debounced-by-synchroniser push buttons:
// PB1/PB2 load operands, PB3 starts an LSB-first add, PB4 clears everything.
module pb_serial_adder #(
  parameter int WIDTH       = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rstn,
  pb_serial_adder_if.slave   bus
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t                         r_state, w_state_nxt;
  logic [3:0][SYNC_STAGES-1:0]    r_sync;
  logic [3:0]                     r_hist;
  logic [3:0]                     w_btn, w_pulse;

  logic [WIDTH-1:0] r_a, r_b, r_sum, r_carry;
  logic [WIDTH-1:0] w_a_nxt, w_b_nxt, w_sum_nxt, w_carry_nxt;
  logic             r_cout, r_av, r_bv, r_busy, r_done, r_c;
  logic             w_cout_nxt, w_av_nxt, w_bv_nxt, w_busy_nxt, w_done_nxt, w_c_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             w_ai, w_bi, w_maj;

  assign w_btn = {bus.PB4, bus.PB3, bus.PB2, bus.PB1};

  // Buttons: SYNC_STAGES-deep synchroniser, then a history flop for edge detect.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync <= '0;
      r_hist <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        r_sync[b] <= {r_sync[b][SYNC_STAGES-2:0], w_btn[b]};
        r_hist[b] <= r_sync[b][SYNC_STAGES-1];
      end
    end
  end

  always_comb begin
    w_pulse = '0;
    for (int b = 0; b < 4; b++) begin
      w_pulse[b] = r_sync[b][SYNC_STAGES-1] & ~r_hist[b];
    end
  end

  assign w_ai  = r_a[r_idx];
  assign w_bi  = r_b[r_idx];
  assign w_maj = (w_ai & w_bi) | (w_ai & r_c) | (w_bi & r_c);

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_sum_nxt   = r_sum;
    w_carry_nxt = r_carry;
    w_cout_nxt  = r_cout;
    w_av_nxt    = r_av;
    w_bv_nxt    = r_bv;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_c_nxt     = r_c;
    w_idx_nxt   = r_idx;

    if (w_pulse[3]) begin
      w_state_nxt = IDLE;
      w_a_nxt     = '0;
      w_b_nxt     = '0;
      w_sum_nxt   = '0;
      w_carry_nxt = '0;
      w_cout_nxt  = 1'b0;
      w_av_nxt    = 1'b0;
      w_bv_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_c_nxt     = 1'b0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          // Operand loads win over a start arriving in the same cycle.
          if (w_pulse[0] || w_pulse[1]) begin
            if (w_pulse[0]) begin
              w_a_nxt  = bus.sw;
              w_av_nxt = 1'b1;
            end
            if (w_pulse[1]) begin
              w_b_nxt  = bus.sw;
              w_bv_nxt = 1'b1;
            end
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b0;
          end else if (w_pulse[2] && r_av && r_bv) begin
            w_c_nxt     = bus.cin;
            w_sum_nxt   = '0;
            w_carry_nxt = '0;
            w_cout_nxt  = 1'b0;
            w_idx_nxt   = '0;
            w_busy_nxt  = 1'b1;
            w_done_nxt  = 1'b0;
            w_state_nxt = ADD;
          end
        end
        ADD: begin
          w_sum_nxt[r_idx]   = w_ai ^ w_bi ^ r_c;
          w_carry_nxt[r_idx] = w_maj;
          w_c_nxt            = w_maj;
          if (r_idx == IDX_W'(WIDTH-1)) begin
            w_cout_nxt  = w_maj;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= '0;
      r_cout  <= 1'b0;
      r_av    <= 1'b0;
      r_bv    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_c     <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_sum   <= w_sum_nxt;
      r_carry <= w_carry_nxt;
      r_cout  <= w_cout_nxt;
      r_av    <= w_av_nxt;
      r_bv    <= w_bv_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_c     <= w_c_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  assign bus.sum     = r_sum;
  assign bus.carry   = r_carry;
  assign bus.cout    = r_cout;
  assign bus.a_valid = r_av;
  assign bus.b_valid = r_bv;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
endmodule

// File: tb/tb_pb_serial_adder.sv
// Randomised bench for pb_serial_adder against an arithmetic reference model
// (7-bit instance for most scenarios, 16-bit instance for the wide add).
module tb_pb_serial_adder;
  localparam int W    = 7;
  localparam int W2   = 16;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pb_serial_adder_if #(.WIDTH(W))  bus();
  pb_serial_adder_if #(.WIDTH(W2)) bus16();

  pb_serial_adder #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  pb_serial_adder #(.WIDTH(W2), .SYNC_STAGES(SYNC)) dut16 (
    .clk (clk),
    .rstn(rstn),
    .bus (bus16)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] m_a, m_b, m_sum, m_carry;
  logic         m_cout, m_av, m_bv, m_done;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    m_a = '0; m_b = '0; m_sum = '0; m_carry = '0;
    m_cout = 1'b0; m_av = 1'b0; m_bv = 1'b0; m_done = 1'b0;
  endfunction

  // Expected results straight from integer addition of the operands.
  function automatic void model_add(input logic c);
    longint sa, sb, t, msk;
    sa = longint'(m_a);
    sb = longint'(m_b);
    t  = sa + sb + longint'(c);
    m_sum  = W'(t);
    m_cout = t[W];
    for (int i = 0; i < W; i++) begin
      msk = (longint'(1) << (i + 1)) - 1;
      m_carry[i] = ((((sa & msk) + (sb & msk) + longint'(c)) >> (i + 1)) & 1) != 0;
    end
    m_done = 1'b1;
  endfunction

  task automatic check_all(input string tag);
    @(negedge clk);
    check_eq($sformatf("%s.sum", tag),   64'(bus.sum),     64'(m_sum));
    check_eq($sformatf("%s.carry", tag), 64'(bus.carry),   64'(m_carry));
    check_eq($sformatf("%s.cout", tag),  64'(bus.cout),    64'(m_cout));
    check_eq($sformatf("%s.av", tag),    64'(bus.a_valid), 64'(m_av));
    check_eq($sformatf("%s.bv", tag),    64'(bus.b_valid), 64'(m_bv));
    check_eq($sformatf("%s.busy", tag),  64'(bus.busy),    64'(0));
    check_eq($sformatf("%s.done", tag),  64'(bus.done),    64'(m_done));
    @(posedge clk);
    #1;
  endtask

  // mask bits: 0=PB1, 1=PB2, 2=PB3, 3=PB4; all raised together, same sw.
  task automatic press(input logic [3:0] mask, input logic [W-1:0] v);
    bus.sw = v;
    {bus.PB4, bus.PB3, bus.PB2, bus.PB1} = mask;
    tick(3);
    {bus.PB4, bus.PB3, bus.PB2, bus.PB1} = 4'b0000;
    tick(SYNC + 2);
    if (mask[3]) begin
      model_clear();
    end else if (mask[1:0] != 2'b00) begin
      if (mask[0]) begin m_a = v; m_av = 1'b1; end
      if (mask[1]) begin m_b = v; m_bv = 1'b1; end
      m_done = 1'b0;
    end
  endtask

  task automatic do_add(input string tag, input logic c, input bit expect_start);
    int first, cnt, done_k;
    first = -1; cnt = 0; done_k = -1;
    bus.cin = c;
    bus.PB3 = 1'b1;
    for (int k = 1; k <= W + SYNC + 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) bus.PB3 = 1'b0;
      @(negedge clk);
      if (bus.busy) begin
        if (first < 0) first = k;
        cnt++;
      end
      if (bus.done && done_k < 0) done_k = k;
    end
    @(posedge clk);
    #1;
    if (expect_start) begin
      check_eq($sformatf("%s.start", tag), 64'(first),  64'(SYNC + 1));
      check_eq($sformatf("%s.bcyc", tag),  64'(cnt),    64'(W));
      check_eq($sformatf("%s.dk", tag),    64'(done_k), 64'(SYNC + 1 + W));
      model_add(c);
    end else begin
      check_eq($sformatf("%s.nobusy", tag), 64'(cnt), 64'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] va, vb;
    int first, cnt, done_k;

    bus.sw = '0; bus.cin = 1'b0;
    {bus.PB4, bus.PB3, bus.PB2, bus.PB1} = 4'b0000;
    bus16.sw = '0; bus16.cin = 1'b0;
    {bus16.PB4, bus16.PB3, bus16.PB2, bus16.PB1} = 4'b0000;
    model_clear();

    rstn = 1'b0;
    tick(3);
    check_all("rst");
    rstn = 1'b1;
    tick(2);

    // 100 + 27 + 0
    press(4'b0001, 7'd100);
    press(4'b0010, 7'd27);
    do_add("add100_27", 1'b0, 1'b1);
    check_all("add100_27");
    check_eq("add100_27.sumabs", 64'(bus.sum), 64'(127));

    // Load from DONE keeps the old result, then 127 + 1
    press(4'b0001, 7'd127);
    check_all("load_in_done");
    press(4'b0010, 7'd1);
    do_add("add127_1", 1'b0, 1'b1);
    check_all("add127_1");
    check_eq("add127_1.carryabs", 64'(bus.carry), 64'h7F);
    tick(10);
    check_all("done_hold");

    // Only A valid: start ignored
    press(4'b1000, '0);
    check_all("clear");
    press(4'b0001, 7'd45);
    do_add("only_a", 1'b1, 1'b0);
    check_all("only_a");

    // Clear beats a simultaneous load
    press(4'b1001, 7'd9);
    check_all("clr_vs_load");

    // Clear in the middle of an add
    press(4'b0001, 7'd77);
    press(4'b0010, 7'd88);
    bus.cin = 1'b1;
    bus.PB3 = 1'b1;
    tick(3);
    bus.PB3 = 1'b0;
    bus.PB4 = 1'b1;
    tick(2);
    @(negedge clk);
    check_eq("abort.busy_before", 64'(bus.busy), 64'(1));
    @(posedge clk);
    #1;
    bus.PB4 = 1'b0;
    model_clear();
    check_all("abort");
    tick(SYNC + 2);
    do_add("abort_restart", 1'b0, 1'b0);
    check_all("abort_restart");

    // Start coinciding with a load: load wins, no add
    press(4'b0001, 7'd10);
    press(4'b0010, 7'd20);
    press(4'b0101, 7'd33);
    check_all("pb3_with_pb1");
    do_add("after_coinc", 1'b0, 1'b1);
    check_all("after_coinc");

    // Random operands, separate or simultaneous loads
    for (int it = 0; it < 25; it++) begin
      va = W'($urandom);
      vb = W'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        press(4'b0011, va);
      end else begin
        press(4'b0001, va);
        press(4'b0010, vb);
      end
      do_add($sformatf("rnd%0d", it), 1'($urandom), 1'b1);
      check_all($sformatf("rnd%0d", it));
    end

    // PB1 held 50 cycles while sw changes: exactly one capture
    bus.PB1 = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      bus.sw = W'($urandom);
      if (k == SYNC + 1) m_a = bus.sw;
      tick(1);
    end
    bus.PB1 = 1'b0;
    tick(SYNC + 2);
    m_av = 1'b1;
    m_done = 1'b0;
    check_all("hold_pb1");
    press(4'b0010, 7'd0);
    do_add("hold_pb1_add", 1'b0, 1'b1);
    check_all("hold_pb1_add");

    // Reset mid-add
    press(4'b0001, 7'd99);
    press(4'b0010, 7'd5);
    bus.cin = 1'b0;
    bus.PB3 = 1'b1;
    tick(3);
    bus.PB3 = 1'b0;
    tick(2);
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    model_clear();
    check_all("rst_mid_add");

    // Button held across reset release still presses
    rstn = 1'b0;
    bus.sw = 7'd55;
    bus.PB1 = 1'b1;
    tick(3);
    check_all("rst_held");
    rstn = 1'b1;
    tick(SYNC + 3);
    bus.PB1 = 1'b0;
    tick(SYNC + 2);
    m_a = 7'd55;
    m_av = 1'b1;
    check_all("held_release");
    press(4'b0010, 7'd0);
    do_add("held_add", 1'b0, 1'b1);
    check_all("held_add");
    check_eq("held_add.sumabs", 64'(bus.sum), 64'(55));

    // 16-bit instance: FFFF + 0 + 1
    bus16.sw = 16'hFFFF;
    bus16.PB1 = 1'b1;
    tick(3);
    bus16.PB1 = 1'b0;
    tick(SYNC + 2);
    bus16.sw = 16'h0000;
    bus16.PB2 = 1'b1;
    tick(3);
    bus16.PB2 = 1'b0;
    tick(SYNC + 2);
    bus16.cin = 1'b1;
    bus16.PB3 = 1'b1;
    first = -1; cnt = 0; done_k = -1;
    for (int k = 1; k <= W2 + SYNC + 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) bus16.PB3 = 1'b0;
      @(negedge clk);
      if (bus16.busy) begin
        if (first < 0) first = k;
        cnt++;
      end
      if (bus16.done && done_k < 0) done_k = k;
    end
    check_eq("w16.start", 64'(first),        64'(SYNC + 1));
    check_eq("w16.bcyc",  64'(cnt),          64'(W2));
    check_eq("w16.dk",    64'(done_k),       64'(SYNC + 1 + W2));
    check_eq("w16.sum",   64'(bus16.sum),    64'(0));
    check_eq("w16.carry", 64'(bus16.carry),  64'hFFFF);
    check_eq("w16.cout",  64'(bus16.cout),   64'(1));
    check_eq("w16.done",  64'(bus16.done),   64'(1));
    check_eq("w16.busy",  64'(bus16.busy),   64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pb_serial_adder.md
PB_SERIAL_ADDER -- requirements
Module: pb_serial_adder

Interface
REQ-001 Parameter WIDTH, default 7, operand/sum width in bits (legal range 2..32).
REQ-002 Parameter SYNC_STAGES, default 2, push-button synchroniser depth (legal range 2..4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 sw  input  WIDTH  operand value source for PB1/PB2 captures.
REQ-006 cin  input  1  carry-in, sampled on the add-start pulse.
REQ-007 PB1  input  1  asynchronous push button: load operand A from sw.
REQ-008 PB2  input  1  asynchronous push button: load operand B from sw.
REQ-009 PB3  input  1  asynchronous push button: start addition.
REQ-010 PB4  input  1  asynchronous push button: clear.
REQ-011 sum  output  WIDTH  result register, filled LSB-first during the add.
REQ-012 carry  output  WIDTH  carry[i] = carry out of bit i.
REQ-013 cout  output  1  final carry out, equals carry[WIDTH-1] once done.
REQ-014 a_valid, b_valid  output  1 each  operand A/B has been captured since the last clear.
REQ-015 busy  output  1  high while the add is in progress.
REQ-016 done  output  1  high while a completed result is held.

Function
REQ-017 Each PBx SHALL pass through a SYNC_STAGES-flop synchroniser plus one history flop; its press pulse is high for exactly one cycle when the synchronised level goes 0->1.
REQ-018 A press pulse SHALL occur SYNC_STAGES+1 rising edges after PBx rises; holding PBx high SHALL produce exactly one pulse.
REQ-019 The FSM SHALL have states IDLE, ADD and DONE.
REQ-020 PB4 pulse: from any state, the FSM goes to IDLE and clears A, B, sum, carry, cout, a_valid, b_valid, busy and done to 0 on the next edge; PB4 overrides every other pulse in the same cycle.
REQ-021 PB1 pulse in IDLE or DONE: A <= sw and a_valid <= 1. If in DONE, the FSM goes to IDLE and done <= 0; sum, carry and cout keep their values.
REQ-022 PB2 pulse: same as REQ-021 for B and b_valid.
REQ-023 Simultaneous PB1 and PB2 pulses SHALL load the same sw value into both A and B.
REQ-024 PB1/PB2/PB3 pulses SHALL be ignored while in ADD.
REQ-025 PB3 pulse in IDLE or DONE with a_valid=b_valid=1: cin is latched, sum/carry/cout clear to 0, bit index clears to 0, busy <= 1, done <= 0, and the FSM goes to ADD.
REQ-026 A PB3 pulse with either operand invalid SHALL be ignored with no state change; a PB3 pulse coinciding with PB1 or PB2 SHALL be ignored, and the loads take effect.
REQ-027 ADD processes one bit per cycle, index i = 0..WIDTH-1:
- sum[i] <= A[i]^B[i]^c.
- carry[i] <= majority(A[i],B[i],c).
- c is the latched cin for i=0, else carry[i-1].
REQ-028 After bit WIDTH-1 is written, cout <= carry out of that bit, busy <= 0, done <= 1, and the FSM goes to DONE. ADD therefore lasts exactly WIDTH cycles.
REQ-029 The result SHALL be correct modulo 2^WIDTH, with cout as bit WIDTH of A+B+cin. Operands are unsigned.
REQ-030 In DONE, sum, carry, cout and done SHALL hold until a PB1, PB2, PB3 or PB4 pulse.
REQ-031 Bit-index wrap SHALL never occur; the index counter is sized to hold WIDTH-1.

Reset
REQ-032 With rstn=0 at a rising edge, all outputs and internal registers (including synchroniser and history flops) SHALL be 0 and the FSM SHALL be in IDLE from the next cycle.
REQ-033 Reset asserted mid-ADD SHALL abort the add with no partial result retained.
REQ-034 A button already held high when rstn is released SHALL generate a press pulse, because the history flop resets to 0.

Verification
REQ-035 WIDTH=7: sw=100 + PB1, then sw=27 + PB2, cin=0, then PB3 -> busy for 7 cycles; then sum=127, carry=0, cout=0, done=1.
REQ-036 WIDTH=7: A=127, B=1, cin=0, PB3 -> sum=0, carry=7'b1111111, cout=1 after 7 cycles.
REQ-037 Only PB1 pressed (A loaded), then PB3 -> no busy, FSM stays in IDLE, sum unchanged, b_valid=0.
REQ-038 PB4 pressed at ADD cycle 3 -> all outputs 0 and the FSM in IDLE one cycle after the pulse; a subsequent PB3 is ignored (a_valid=0).
REQ-039 PB1 held 50 cycles while sw changes -> A equals the sw value at the single pulse cycle; a_valid=1.
REQ-040 WIDTH=16: A=16'hFFFF, B=16'h0000, cin=1 -> sum=0, cout=1, done asserted 16 cycles after start.
